// File: rtl/framer_pkg.sv
// Shared types and default sizes for the sample framer slice.
package framer_pkg;

    localparam int FRAMER_N     = 256;
    localparam int FRAMER_WIDTH = 12;
    localparam int FRAMER_CNT_W = 16;

    typedef logic signed [FRAMER_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } framer_state_t;

endpackage

// File: rtl/sample_framer_bank.sv
// sample_bank: N-entry sample register bank with one write port, bulk read,
// synchronous clear and a lower-half bulk load used for overlapped framing.
module sample_bank
    import framer_pkg::*;
#(
    parameter int N     = FRAMER_N,
    parameter int WIDTH = FRAMER_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [$clog2(N)-1:0]    wr_idx,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic                    half_ld,
    input  logic signed [WIDTH-1:0] half_data [N/2],
    output logic signed [WIDTH-1:0] rd_data [N]
);

    // Storage: half-load fills [0..N/2-1]; the single write never targets that range on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                rd_data[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                rd_data[i] <= '0;
            end
        end else begin
            if (half_ld) begin
                for (int i = 0; i < N/2; i++) begin
                    rd_data[i] <= half_data[i];
                end
            end
            if (wr_en) begin
                rd_data[wr_idx] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/sample_framer.sv
// sample_framer: ping-pong framing of the sample stream into N-sample frames for fft_256.
// Optional 50% frame overlap is enabled by defining SAMPLE_FRAMER_OVERLAP_EN.
module sample_framer
    import framer_pkg::*;
#(
    parameter int WIDTH = FRAMER_WIDTH,
    parameter int N     = FRAMER_N,
    parameter int CNT_W = FRAMER_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic                    fft_done,
    output logic                    fft_start,
    output logic signed [WIDTH-1:0] time_samples [N],
    output logic                    busy,
    output logic [CNT_W-1:0]        frame_count,
    output logic [CNT_W-1:0]        drop_count
);

    localparam int IDX_W = $clog2(N);
`ifdef SAMPLE_FRAMER_OVERLAP_EN
    localparam logic [IDX_W-1:0] FILL_START = IDX_W'(N/2);
`else
    localparam logic [IDX_W-1:0] FILL_START = '0;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

    framer_state_t           state_r;
    framer_state_t           state_nxt_s;
    logic                    fill_sel_r;
    logic                    pending_r;
    logic [IDX_W-1:0]        wr_idx_r;
    logic                    fft_start_r;
    logic                    busy_r;
    logic [CNT_W-1:0]        frame_count_r;
    logic [CNT_W-1:0]        drop_count_r;
    logic                    swap_s;
    logic                    wr_en_s;
    logic                    drop_s;
    logic [IDX_W-1:0]        wr_addr_s;
    logic [1:0]              bank_wr_s;
    logic [1:0]              half_ld_s;
    logic signed [WIDTH-1:0] bank0_rd_s [N];
    logic signed [WIDTH-1:0] bank1_rd_s [N];
    logic signed [WIDTH-1:0] half0_s [N/2];
    logic signed [WIDTH-1:0] half1_s [N/2];

    // Fill-side steering: on the swap edge the sample lands in the bank that becomes the fill bank.
    always_comb begin
        swap_s    = (state_r == IDLE) && pending_r;
        wr_en_s   = sample_valid && (!pending_r || swap_s);
        drop_s    = sample_valid && pending_r && !swap_s;
        wr_addr_s = swap_s ? FILL_START : wr_idx_r;
        if (!wr_en_s) begin
            bank_wr_s = 2'b00;
        end else if (fill_sel_r ^ swap_s) begin
            bank_wr_s = 2'b10;
        end else begin
            bank_wr_s = 2'b01;
        end
    end

    // Overlap carry: the bank becoming the fill bank inherits the upper half of the completed frame.
    always_comb begin
        for (int i = 0; i < N/2; i++) begin
            half0_s[i] = bank1_rd_s[i + N/2];
            half1_s[i] = bank0_rd_s[i + N/2];
        end
`ifdef SAMPLE_FRAMER_OVERLAP_EN
        if (swap_s) begin
            half_ld_s = fill_sel_r ? 2'b01 : 2'b10;
        end else begin
            half_ld_s = 2'b00;
        end
`else
        half_ld_s = 2'b00;
`endif
    end

    // FFT handshake sequencing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = pending_r ? START : IDLE;
            START:   state_nxt_s = BUSY;
            BUSY:    state_nxt_s = fft_done ? IDLE : BUSY;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control state, bank select, write index and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            fill_sel_r    <= 1'b0;
            pending_r     <= 1'b0;
            wr_idx_r      <= '0;
            fft_start_r   <= 1'b0;
            busy_r        <= 1'b0;
            frame_count_r <= '0;
            drop_count_r  <= '0;
        end else begin
            state_r     <= state_nxt_s;
            fft_start_r <= (state_nxt_s == START);
            busy_r      <= (state_nxt_s != IDLE);
            if (swap_s) begin
                fill_sel_r    <= ~fill_sel_r;
                frame_count_r <= frame_count_r + CNT_W'(1);
            end
            if (wr_en_s && (wr_addr_s == LAST_IDX)) begin
                pending_r <= 1'b1;
            end else if (swap_s) begin
                pending_r <= 1'b0;
            end
            if (wr_en_s) begin
                wr_idx_r <= (wr_addr_s == LAST_IDX) ? '0 : wr_addr_s + IDX_W'(1);
            end else if (swap_s) begin
                wr_idx_r <= FILL_START;
            end
            if (drop_s && (drop_count_r != '1)) begin
                drop_count_r <= drop_count_r + CNT_W'(1);
            end
        end
    end

    sample_bank #(.N(N), .WIDTH(WIDTH)) u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .wr_en    (bank_wr_s[0]),
        .wr_idx   (wr_addr_s),
        .wr_data  (sample_in),
        .half_ld  (half_ld_s[0]),
        .half_data(half0_s),
        .rd_data  (bank0_rd_s)
    );

    sample_bank #(.N(N), .WIDTH(WIDTH)) u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .wr_en    (bank_wr_s[1]),
        .wr_idx   (wr_addr_s),
        .wr_data  (sample_in),
        .half_ld  (half_ld_s[1]),
        .half_data(half1_s),
        .rd_data  (bank1_rd_s)
    );

    // Present bank is whichever bank is not being filled.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            time_samples[i] = fill_sel_r ? bank0_rd_s[i] : bank1_rd_s[i];
        end
    end

    assign fft_start   = fft_start_r;
    assign busy        = busy_r;
    assign frame_count = frame_count_r;
    assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_sample_framer.sv
// Self-checking bench for sample_framer; reference model treats the accepted sample stream as one sequence.
module tb_sample_framer;
    import framer_pkg::*;

    localparam int N = FRAMER_N;
`ifdef SAMPLE_FRAMER_OVERLAP_EN
    localparam int HOP = N/2;
`else
    localparam int HOP = N;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    sample_t     sample_in;
    logic        sample_valid;
    logic        fft_done;
    logic        fft_start;
    sample_t     time_samples [N];
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    // Reference: every accepted sample in order; frame f is acc_q[f*HOP +: N].
    sample_t acc_q [$];
    int      m_issued;
    int      m_phase;   // 0 idle, 1 start cycle, 2 waiting for done
    int      m_drop;

    always #5 clk = ~clk;

    sample_framer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .fft_done    (fft_done),
        .fft_start   (fft_start),
        .time_samples(time_samples),
        .busy        (busy),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    function automatic sample_t exp_sample(input int i);
        if (m_issued == 0) return '0;
        return acc_q[(m_issued - 1) * HOP + i];
    endfunction

    task automatic model_reset();
        acc_q.delete();
        m_issued = 0;
        m_phase  = 0;
        m_drop   = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, return #1 after it.
    task automatic tick(input logic v, input sample_t d, input logic done);
        int complete;
        bit pend;
        bit swap;
        sample_valid = v;
        sample_in    = d;
        fft_done     = done;
        @(posedge clk);
        if (rst_n) begin
            complete = (acc_q.size() >= N) ? (acc_q.size() - N) / HOP + 1 : 0;
            pend     = complete > m_issued;
            swap     = (m_phase == 0) && pend;
            if (v) begin
                if (pend && !swap) begin
                    if (m_drop != 65535) m_drop++;
                end else begin
                    acc_q.push_back(d);
                end
            end
            if (swap) begin
                m_phase = 1;
                m_issued++;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2 && done) begin
                m_phase = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        sample_in    = '0;
        fft_done     = 1'b0;
        rst_n        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < N; i++) if (time_samples[i] !== sample_t'(0)) errs++;
        checks++; if (fft_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", fft_start); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        checks++; if (errs != 0) begin failures++; $display("FAIL reset_samples: %0d nonzero entries", errs); end
    endtask

    task automatic test_single_frame();
        int errs;
        for (int i = 0; i < N; i++) begin
            tick(1'b1, sample_t'(i), 1'b0);
            checks++; if (fft_start !== 1'b0) begin failures++; $display("FAIL single_early_start: got %b at sample %0d", fft_start, i); end
        end
        tick(1'b0, '0, 1'b0);
        errs = 0;
        for (int i = 0; i < N; i++) if (time_samples[i] !== sample_t'(i)) errs++;
        checks++; if (fft_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b want 1", fft_start); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL single_frame_count: got %0d want 1", frame_count); end
        checks++; if (errs != 0) begin failures++; $display("FAIL single_data: %0d entries differ, [5]=%0d want 5", errs, time_samples[5]); end
        tick(1'b0, '0, 1'b0);
        checks++; if (fft_start !== 1'b0) begin failures++; $display("FAIL single_pulse_width: got %b want 0", fft_start); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_hold: got %b want 1", busy); end
    endtask

    task automatic test_overrun();
        int errs;
        for (int i = 0; i < N + 10; i++) begin
            tick(1'b1, sample_t'(N + i), 1'b0);
            checks++; if (fft_start !== 1'b0) begin failures++; $display("FAIL overrun_start: got %b at sample %0d", fft_start, i); end
        end
        checks++; if (drop_count !== 16'(N + 10 - HOP)) begin failures++; $display("FAIL overrun_drop_count: got %0d want %0d", drop_count, N + 10 - HOP); end
        checks++; if (drop_count !== 16'(m_drop)) begin failures++; $display("FAIL overrun_drop_model: got %0d want %0d", drop_count, m_drop); end
        tick(1'b0, '0, 1'b1);
        checks++; if (busy !== 1'b0 || fft_start !== 1'b0) begin failures++; $display("FAIL overrun_idle_gap: busy %b start %b want 0 0", busy, fft_start); end
        tick(1'b0, '0, 1'b0);
        errs = 0;
        for (int i = 0; i < N; i++) if (time_samples[i] !== sample_t'(HOP + i)) errs++;
        checks++; if (fft_start !== 1'b1) begin failures++; $display("FAIL overrun_second_start: got %b want 1", fft_start); end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL overrun_frame_count: got %0d want 2", frame_count); end
        checks++; if (errs != 0) begin failures++; $display("FAIL overrun_data: %0d differ, [0]=%0d want %0d", errs, time_samples[0], HOP); end
    endtask

    task automatic test_done_ignored();
        tick(1'b0, '0, 1'b1);
        checks++; if (busy !== 1'b1 || fft_start !== 1'b0) begin failures++; $display("FAIL done_in_start: busy %b start %b want 1 0", busy, fft_start); end
        tick(1'b0, '0, 1'b1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_in_busy: busy %b want 0", busy); end
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, '0, 1'b1);
            checks++; if (busy !== 1'b0 || fft_start !== 1'b0) begin failures++; $display("FAIL done_in_idle: busy %b start %b want 0 0", busy, fft_start); end
        end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL done_frame_count: got %0d want 2", frame_count); end
    endtask

    task automatic test_reset_mid();
        int errs;
        for (int i = 0; i < HOP + 100; i++) begin
            tick(1'b1, sample_t'($urandom), 1'b0);
            checks++; if (fft_start !== (m_phase == 1)) begin failures++; $display("FAIL midrst_pre_start: got %b want %0d", fft_start, m_phase == 1); end
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        sample_valid = 1'b0;
        #1;
        errs = 0;
        for (int i = 0; i < N; i++) if (time_samples[i] !== sample_t'(0)) errs++;
        checks++; if (busy !== 1'b0 || fft_start !== 1'b0) begin failures++; $display("FAIL midrst_outputs: busy %b start %b want 0 0", busy, fft_start); end
        checks++; if (frame_count !== 16'd0 || drop_count !== 16'd0) begin failures++; $display("FAIL midrst_counts: frames %0d drops %0d want 0 0", frame_count, drop_count); end
        checks++; if (errs != 0) begin failures++; $display("FAIL midrst_samples: %0d nonzero entries", errs); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            tick(1'b1, sample_t'($urandom), 1'b0);
            checks++; if (fft_start !== 1'b0) begin failures++; $display("FAIL midrst_early_start: got %b at sample %0d", fft_start, i); end
        end
        tick(1'b0, '0, 1'b0);
        errs = 0;
        for (int i = 0; i < N; i++) if (time_samples[i] !== exp_sample(i)) errs++;
        checks++; if (fft_start !== 1'b1 || frame_count !== 16'd1) begin failures++; $display("FAIL midrst_restart: start %b frames %0d want 1 1", fft_start, frame_count); end
        checks++; if (errs != 0) begin failures++; $display("FAIL midrst_data: %0d entries differ", errs); end
    endtask

    task automatic test_extremes();
        int      errs;
        bit      seen;
        sample_t d;
        repeat (3) tick(1'b0, '0, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 3 * N + 10; c++) begin
            case ($urandom_range(0, 2))
                0:       d = sample_t'(-2048);
                1:       d = sample_t'(2047);
                default: d = sample_t'($urandom);
            endcase
            tick((c % 3) == 0, d, 1'b0);
            checks++; if (fft_start !== (m_phase == 1)) begin failures++; $display("FAIL sparse_start: got %b want %0d cycle %0d", fft_start, m_phase == 1, c); end
            if (m_phase == 1) begin
                errs = 0;
                for (int i = 0; i < N; i++) if (time_samples[i] !== exp_sample(i)) errs++;
                checks++; if (errs != 0) begin failures++; $display("FAIL sparse_data: %0d entries differ", errs); end
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL sparse_timeout: got no start want one"); end
    endtask

    task automatic test_back_to_back();
        int errs;
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 3) != 0, sample_t'($urandom), $urandom_range(0, 7) == 0);
            errs = 0;
            for (int i = 0; i < N; i++) if (time_samples[i] !== exp_sample(i)) errs++;
            checks++; if (fft_start !== (m_phase == 1)) begin failures++; $display("FAIL b2b_start: got %b want %0d cycle %0d", fft_start, m_phase == 1, c); end
            checks++; if (busy !== (m_phase != 0)) begin failures++; $display("FAIL b2b_busy: got %b want %0d cycle %0d", busy, m_phase != 0, c); end
            checks++; if (frame_count !== 16'(m_issued)) begin failures++; $display("FAIL b2b_frame_count: got %0d want %0d", frame_count, m_issued); end
            checks++; if (drop_count !== 16'(m_drop)) begin failures++; $display("FAIL b2b_drop_count: got %0d want %0d", drop_count, m_drop); end
            checks++; if (errs != 0) begin failures++; $display("FAIL b2b_data: %0d entries differ cycle %0d", errs, c); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_done_ignored();
        test_reset_mid();
        test_extremes();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
